// File: rtl/softmax_exp_accumulator_pkg.sv
// Shared softmax datapath definitions: fixed-point format,
// default sizing and accumulator state encoding.
package softmax_exp_accumulator_pkg;

   localparam int DEF_LEN   = 16;
   localparam int DEF_FRAC  = 13;
   localparam int DEF_DEPTH = 16;

   localparam logic [DEF_LEN-1:0] ONE_FX = DEF_LEN'(1 << DEF_FRAC);

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_DRAIN = 1'b1
   } acc_state_e;

endpackage

// File: rtl/softmax_exp_buf.sv
// Exponential vector buffer: DEPTH x W register file,
// one write port, one asynchronous read port, no reset on contents.
module softmax_exp_buf #(
   parameter int W     = 17,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [DEPTH];

   // Write the accepted exponential into its slot.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/softmax_exp_accumulator.sv
// Forms exp = cosh + sinh per element, buffers one vector and its sum,
// then streams the buffered exponentials out paired with the final sum.
module softmax_exp_accumulator
   import softmax_exp_accumulator_pkg::*;
#(
   parameter  int LEN   = DEF_LEN,
   parameter  int DEPTH = DEF_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [LEN-1:0]    cosh,
   input  logic [LEN-1:0]    sinh,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LEN:0]      out_exp,
   output logic [LEN+AW:0]   out_sum,
   output logic              out_last,
   output logic              err_ovf
);

   acc_state_e       state_q, state_d;
   logic [AW:0]      count_q, count_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LEN+AW:0]  sum_q, sum_d;
   logic             err_q, err_d;

   logic [LEN:0]     exp_raw;
   logic [LEN:0]     exp_clamp;
   logic [LEN:0]     rd_data;
   logic             buf_we;
   logic             full;
   logic             drain;
   logic             at_last;

   // Negative exp can only come from CORDIC rounding error; clamp to zero.
   assign exp_raw   = {cosh[LEN-1], cosh} + {sinh[LEN-1], sinh};
   assign exp_clamp = exp_raw[LEN] ? '0 : exp_raw;

   assign full    = (count_q == (AW+1)'(DEPTH - 1));
   assign drain   = (state_q == ST_DRAIN);
   assign at_last = ({1'b0, rd_ptr_q} == (count_q - 1'b1));

   softmax_exp_buf #(
      .W     (LEN + 1),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_buf (
      .clk     (clk),
      .we_i    (buf_we),
      .waddr_i (count_q[AW-1:0]),
      .wdata_i (exp_clamp),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_data)
   );

   // Outputs come only from buffer/sum registers, zero outside drain.
   assign out_exp  = drain ? rd_data : '0;
   assign out_sum  = drain ? sum_q : '0;
   assign out_last = drain && at_last;
   assign err_ovf  = err_q;

   // Next-state, counters, accumulator and handshakes.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      rd_ptr_d  = rd_ptr_q;
      sum_d     = sum_q;
      err_d     = err_q;
      buf_we    = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         ST_ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               buf_we  = 1'b1;
               sum_d   = sum_q + {{AW{1'b0}}, exp_clamp};
               count_d = count_q + 1'b1;
               if (in_last || full) begin
                  state_d = ST_DRAIN;
               end
               if (full && !in_last) begin
                  err_d = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (at_last) begin
                  rd_ptr_d = '0;
                  count_d  = '0;
                  sum_d    = '0;
                  state_d  = ST_ACCUM;
               end else begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_ACCUM;
         count_q  <= '0;
         rd_ptr_q <= '0;
         sum_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         sum_q    <= sum_d;
         err_q    <= err_d;
      end
   end

endmodule
